// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory bus between the
// instruction-fetch port (IF) and the load/store data port (D).
// D has fixed priority; a saturating starvation counter hands IF the bus
// after STARVE_LIMIT consecutive lost arbitrations. An in-flight fetch can
// be discarded with if_kill: the bus cycle still completes, only if_done
// is suppressed.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_kill,
    output logic                if_done,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_done,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                bus_req,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W/8-1:0] bus_be,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic                bus_ack,
    input  logic [DATA_W-1:0]   bus_rdata,
    output logic                busy
);

    localparam logic [3:0] SLIM = 4'(STARVE_LIMIT);

    // RESP is split per owner so the done pulse needs no separate owner flag.
    typedef enum logic [2:0] {
        S_IDLE,
        S_IF_BUS,
        S_D_BUS,
        S_IF_RESP,
        S_D_RESP
    } state_t;

    state_t     state, state_nx;
    logic [3:0] starve;
    logic       kill_pend;
    logic       grant_d, grant_if;

    // Arbitration in IDLE; the two grant terms are mutually exclusive.
    always_comb begin
        grant_d  = 1'b0;
        grant_if = 1'b0;
        if (state == S_IDLE) begin
            grant_d  = d_req && (!if_req || (starve < SLIM));
            grant_if = if_req && !if_kill && (!d_req || (starve >= SLIM));
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    // Next-state logic and done/busy outputs.
    always_comb begin
        state_nx = state;
        if_done  = 1'b0;
        d_done   = 1'b0;
        busy     = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (grant_d)       state_nx = S_D_BUS;
                else if (grant_if) state_nx = S_IF_BUS;
            end
            S_IF_BUS:  if (bus_ack) state_nx = S_IF_RESP;
            S_D_BUS:   if (bus_ack) state_nx = S_D_RESP;
            S_IF_RESP: begin
                if_done  = !kill_pend && !if_kill;
                state_nx = S_IDLE;
            end
            S_D_RESP: begin
                d_done   = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Bus request register: captured on grant, held until acknowledged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
        end else if (grant_d) begin
            bus_req   <= 1'b1;
            bus_we    <= d_we;
            bus_addr  <= d_addr;
            bus_be    <= d_we ? d_be : '1;
            bus_wdata <= d_wdata;
        end else if (grant_if) begin
            bus_req   <= 1'b1;
            bus_we    <= 1'b0;
            bus_addr  <= if_addr;
            bus_be    <= '1;
            bus_wdata <= '0;
        end else if (((state == S_IF_BUS) || (state == S_D_BUS)) && bus_ack) begin
            bus_req   <= 1'b0;
        end
    end

    // Read data capture; a killed fetch still updates if_rdata.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_rdata <= '0;
            d_rdata  <= '0;
        end else begin
            if ((state == S_IF_BUS) && bus_ack)            if_rdata <= bus_rdata;
            if ((state == S_D_BUS) && bus_ack && !bus_we) d_rdata  <= bus_rdata;
        end
    end

    // Starvation counter: counts D wins while IF waits, saturating at the limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve <= '0;
        end else if (grant_if) begin
            starve <= '0;
        end else if (grant_d) begin
            if (!if_req)            starve <= '0;
            else if (starve < SLIM) starve <= starve + 4'd1;
        end
    end

    // Kill-pending flag: remembers a flush seen while the fetch is on the bus.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kill_pend <= 1'b0;
        end else if ((state == S_IF_BUS) && if_kill) begin
            kill_pend <= 1'b1;
        end else if ((state == S_IF_RESP) || (state == S_D_RESP)) begin
            kill_pend <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_kill;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [3:0]  d_be;
    logic [31:0] d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        busy;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .if_req(if_req),
        .if_addr(if_addr),
        .if_kill(if_kill),
        .if_done(if_done),
        .if_rdata(if_rdata),
        .d_req(d_req),
        .d_we(d_we),
        .d_addr(d_addr),
        .d_be(d_be),
        .d_wdata(d_wdata),
        .d_done(d_done),
        .d_rdata(d_rdata),
        .bus_req(bus_req),
        .bus_we(bus_we),
        .bus_addr(bus_addr),
        .bus_be(bus_be),
        .bus_wdata(bus_wdata),
        .bus_ack(bus_ack),
        .bus_rdata(bus_rdata),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst       = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        if_kill   = 1'b0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_be      = '0;
        d_wdata   = '0;
        bus_ack   = 1'b0;
        bus_rdata = '0;

        // Reset state
        step(); step();
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_be", 32'(bus_be), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        rst = 1'b1;
        step();

        // Reset in the middle of a D_BUS transaction
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0040;
        step();
        chk("midrst_pre_bus_req", 32'(bus_req), 32'd1);
        chk("midrst_pre_bus_addr", bus_addr, 32'h40);
        #2 rst = 1'b0;
        #1;
        chk("midrst_bus_req", 32'(bus_req), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_bus_addr", bus_addr, 32'd0);
        chk("midrst_bus_be", 32'(bus_be), 32'd0);
        d_req = 1'b0;
        step();
        rst = 1'b1;
        bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
        step();
        chk("midrst_no_done_a", 32'(d_done), 32'd0);
        chk("midrst_idle_busy", 32'(busy), 32'd0);
        bus_ack = 1'b0;
        step();
        chk("midrst_no_done_b", 32'(d_done), 32'd0);
        chk("midrst_d_rdata", d_rdata, 32'd0);

        // Single fetch, ack two cycles after bus_req rises
        if_req = 1'b1; if_addr = 32'h8000_0000;
        step();
        chk("fetch_bus_req", 32'(bus_req), 32'd1);
        chk("fetch_bus_addr", bus_addr, 32'h8000_0000);
        chk("fetch_bus_be", 32'(bus_be), 32'hF);
        chk("fetch_bus_we", 32'(bus_we), 32'd0);
        step();
        chk("fetch_wait_busreq", 32'(bus_req), 32'd1);
        step();
        bus_ack = 1'b1; bus_rdata = 32'h0000_0093;
        step();
        chk("fetch_if_done", 32'(if_done), 32'd1);
        chk("fetch_d_done", 32'(d_done), 32'd0);
        chk("fetch_bus_req_drop", 32'(bus_req), 32'd0);
        chk("fetch_if_rdata", if_rdata, 32'h0000_0093);
        bus_ack = 1'b0; if_req = 1'b0;
        step();
        chk("fetch_done_pulse", 32'(if_done), 32'd0);
        chk("fetch_idle", 32'(busy), 32'd0);

        // Collision: D write wins over IF
        if_req = 1'b1; if_addr = 32'h0000_0200;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0100; d_be = 4'b0011; d_wdata = 32'hDEAD_BEEF;
        step();
        chk("coll_d_addr", bus_addr, 32'h100);
        chk("coll_d_we", 32'(bus_we), 32'd1);
        chk("coll_d_be", 32'(bus_be), 32'h3);
        chk("coll_d_wdata", bus_wdata, 32'hDEAD_BEEF);
        bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
        step();
        chk("coll_d_done", 32'(d_done), 32'd1);
        chk("coll_if_not_done", 32'(if_done), 32'd0);
        chk("coll_write_no_rdata", d_rdata, 32'd0);
        bus_ack = 1'b0; d_req = 1'b0; d_we = 1'b0;
        step();
        chk("coll_gap_idle", 32'(busy), 32'd0);
        step();
        chk("coll_if_addr", bus_addr, 32'h200);
        chk("coll_if_we", 32'(bus_we), 32'd0);
        chk("coll_if_be", 32'(bus_be), 32'hF);
        bus_ack = 1'b1; bus_rdata = 32'h1111_1111;
        step();
        chk("coll_if_done", 32'(if_done), 32'd1);
        chk("coll_if_rdata", if_rdata, 32'h1111_1111);
        bus_ack = 1'b0; if_req = 1'b0;
        step();

        // Starvation: 4 D wins, then IF, then D resumes (bus_ack tied high)
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300; d_be = '0;
        if_req = 1'b1; if_addr = 32'h0000_0400;
        bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("starve_d%0d_addr", i), bus_addr, 32'h300);
            step();
            chk($sformatf("starve_d%0d_done", i), 32'(d_done), 32'd1);
            step();
        end
        step();
        chk("starve_if_grant", bus_addr, 32'h400);
        step();
        chk("starve_if_done", 32'(if_done), 32'd1);
        chk("starve_if_rdata", if_rdata, 32'h5555_AAAA);
        if_req = 1'b0;
        step();
        step();
        chk("starve_d_resume", bus_addr, 32'h300);
        step();
        chk("starve_d_resume_done", 32'(d_done), 32'd1);
        chk("starve_d_rdata", d_rdata, 32'h5555_AAAA);
        d_req = 1'b0; bus_ack = 1'b0;
        step();

        // Kill while the fetch is on the bus
        if_req = 1'b1; if_addr = 32'h0000_0500;
        step();
        chk("kill_busreq", 32'(bus_req), 32'd1);
        if_kill = 1'b1;
        step();
        if_kill = 1'b0; if_req = 1'b0;
        step();
        chk("kill_bus_held", 32'(bus_req), 32'd1);
        chk("kill_bus_addr_held", bus_addr, 32'h500);
        bus_ack = 1'b1; bus_rdata = 32'h0000_0077;
        step();
        chk("kill_no_done", 32'(if_done), 32'd0);
        bus_ack = 1'b0;
        step();
        chk("kill_rdata", if_rdata, 32'h77);
        chk("kill_idle", 32'(busy), 32'd0);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0600;
        step();
        chk("kill_next_d_addr", bus_addr, 32'h600);
        bus_ack = 1'b1; bus_rdata = 32'h0000_0066;
        step();
        chk("kill_next_d_done", 32'(d_done), 32'd1);
        d_req = 1'b0; bus_ack = 1'b0;
        step();

        // Kill coincident with bus_ack
        if_req = 1'b1; if_addr = 32'h0000_0700;
        step();
        if_kill = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h0000_0088;
        step();
        if_kill = 1'b0;
        chk("killack_no_done", 32'(if_done), 32'd0);
        bus_ack = 1'b0; if_req = 1'b0;
        step();
        chk("killack_rdata", if_rdata, 32'h88);
        chk("killack_no_done_late", 32'(if_done), 32'd0);

        // Fetch after kills completes with a done pulse
        if_req = 1'b1; if_addr = 32'h0000_0900;
        bus_ack = 1'b1; bus_rdata = 32'h0000_0099;
        step();
        step();
        chk("postkill_if_done", 32'(if_done), 32'd1);
        if_req = 1'b0; bus_ack = 1'b0;
        step();

        // Zero-wait back-to-back reads
        d_req = 1'b1; d_we = 1'b0; d_be = '0; bus_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d_addr = 32'h0000_1000 + 32'(4 * i);
            bus_rdata = 32'hA000_0000 + 32'(i);
            step();
            chk($sformatf("zw%0d_busy", i), 32'(busy), 32'd1);
            chk($sformatf("zw%0d_addr", i), bus_addr, 32'h0000_1000 + 32'(4 * i));
            chk($sformatf("zw%0d_be", i), 32'(bus_be), 32'hF);
            step();
            chk($sformatf("zw%0d_done", i), 32'(d_done), 32'd1);
            chk($sformatf("zw%0d_rdata", i), d_rdata, 32'hA000_0000 + 32'(i));
            step();
            chk($sformatf("zw%0d_gap_busy", i), 32'(busy), 32'd0);
            chk($sformatf("zw%0d_gap_done", i), 32'(d_done), 32'd0);
        end
        d_req = 1'b0; bus_ack = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, variable-latency memory bus between two requesters of the core: the instruction-fetch port (IF) and the load/store data port (D).
- Sits between riscv_core and the memory/bus model.
- Registers the selected request onto the bus, holds it until acknowledged, then returns a one-cycle done pulse with registered read data to the owner.
- Fixed priority to D, with a starvation guard for IF.
- Supports discarding an in-flight fetch on pipeline flush.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- STARVE_LIMIT, 4, consecutive lost arbitrations after which IF wins next; legal range 1..15.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held with if_addr until if_done or if_kill.
- if_addr  in  ADDR_W  fetch address.
- if_kill  in  1  flush pulse; cancels a pending or in-flight fetch.
- if_done  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  DATA_W  fetched word.
- d_req  in  1  data request; held with d_we/d_addr/d_be/d_wdata until d_done.
- d_we  in  1  0 read, 1 write.
- d_addr  in  ADDR_W  data address.
- d_be  in  DATA_W/8  byte enables for writes.
- d_wdata  in  DATA_W  write data.
- d_done  out  1  one-cycle pulse; d_rdata valid for reads.
- d_rdata  out  DATA_W  load data.
- bus_req  out  1  request to memory; held until bus_ack.
- bus_we  out  1  write strobe.
- bus_addr  out  ADDR_W  address.
- bus_be  out  DATA_W/8  byte enables; all ones for fetch and data reads.
- bus_wdata  out  DATA_W  write data.
- bus_ack  in  1  one-cycle completion; bus_rdata valid this cycle.
- bus_rdata  in  DATA_W  read data.
- busy  out  1  state != IDLE.

Behaviour:

Reset (rst=0, immediate):
- State IDLE; starve counter 0; kill_pend 0.
- All outputs 0, including rdata, addr and be.
- Reset mid-transaction abandons it; no done pulse is issued after reset release.
- bus_ack arriving while in IDLE is ignored.

States:
- IDLE: arbitrate among active requests.
  - d_req=1 and (if_req=0 or starve<STARVE_LIMIT) -> D_BUS.
  - if_req=1 and if_kill=0 and (d_req=0 or starve>=STARVE_LIMIT) -> IF_BUS.
  - On the transition edge: latch addr/we/be/wdata into bus_* and set bus_req=1.
  - A captured request is not re-sampled; later requester changes are ignored until done.
- IF_BUS / D_BUS: hold bus_* constant.
  - On bus_ack: bus_req<=0, latch bus_rdata into the owner's rdata, go to RESP.
  - Latched rdata holds until the next completion of that port.
- RESP (one cycle): pulse owner done (if_done suppressed when kill_pend=1), clear kill_pend, return to IDLE.
  - Requester must drop or change req in the cycle after done.
  - A new request is accepted from IDLE the following cycle.

Latency:
- Request seen in IDLE at cycle 0 -> bus_req=1 at cycle 1.
- bus_ack at cycle k -> done at cycle k+1.
- Minimum 3 cycles req-to-done (ack at cycle 1); bus_ack is permitted in the same cycle bus_req first rises.

Starvation counter:
- Increments (saturating at STARVE_LIMIT) when D wins while if_req=1.
- Clears when IF is granted, or when D wins with if_req=0.

if_kill:
- In IDLE: suppresses IF arbitration that cycle.
- In IF_BUS: sets kill_pend; the bus transaction still completes (never withdrawn), if_done is suppressed, and if_rdata is still updated.
- In RESP owned by IF: suppresses if_done that cycle.
- Any other state: no effect.

Other rules:
- Simultaneous if_kill and bus_ack in IF_BUS: done suppressed.
- d_we=0: bus_be forced all ones; d_rdata updated on completion.
- d_we=1: d_rdata unchanged; d_done still pulses.
- No address alignment checking; addresses pass through unchanged.

Test Plan:
- Reset: rst low mid-D_BUS with bus_req=1 -> all outputs 0 immediately; after release, bus_ack=1 gives no d_done.
- Single fetch: if_req, if_addr=0x80000000, bus_ack 2 cycles after bus_req with bus_rdata=0x00000093 -> bus_addr=0x80000000, bus_be=4'hF, if_done one cycle after ack, if_rdata=0x00000093, d_done never.
- Collision: if_req and d_req (write, d_addr=0x100, d_be=4'b0011, d_wdata=0xDEADBEEF) in the same cycle -> D served first with bus_we=1, bus_be=4'b0011; then IF; d_done precedes if_done.
- Starvation: d_req held high continuously with if_req=1, STARVE_LIMIT=4 -> exactly 4 D transactions complete, 5th grant goes to IF, counter clears, D then resumes.
- Kill: if_kill pulsed while in IF_BUS and again in a separate run coincident with bus_ack -> bus transaction completes, if_done never asserted, next d_req granted normally.
- Zero-wait bus: bus_ack tied high -> each request completes in 3 cycles; back-to-back d_req sequence of reads returns matching d_rdata in order, busy low one cycle between transactions.
